// File: rtl/qint_iak_master_pkg.sv
// Shared types and default timing for the QBUS interrupt-acknowledge master.
// Timing constants are in 20 MHz clk cycles.
package qint_iak_master_pkg;

  typedef enum logic [2:0] {
    IAK_IDLE,
    IAK_BUSREQ,
    IAK_DIN,
    IAK_IAK,
    IAK_DESK,
    IAK_REL,
    IAK_ABORT
  } iak_state_e;

  localparam int DIN_IAK_DLY_DEF = 4;
  localparam int DESKEW_DEF      = 3;
  localparam int TIMEOUT_DEF     = 200;

  // Highest requesting level strictly above the CPU priority, or 0 when none.
  // Level-7 devices also pull IRQ6; taking the highest line covers that.
  function automatic logic [2:0] highest_irq(input logic [4:7] irq,
                                             input logic [2:0] pri);
    logic [2:0] lvl;
    lvl = '0;
    for (int n = 4; n <= 7; n++) begin
      if (irq[n] && (n > int'(pri))) lvl = 3'(n);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/qint_iak_master_if.sv
// QBUS-side signals of the interrupt protocol: request lines, DIN/IAKO
// daisy-chain origin, reply and data lines.
interface qint_iak_master_if;
  logic [4:7] RIRQ;
  logic       RRPLY;
  logic [15:0] RDAL;
  logic       TDIN;
  logic       TIAKO;

  modport master (input RIRQ, input RRPLY, input RDAL, output TDIN, output TIAKO);
  modport slave  (output RIRQ, output RRPLY, output RDAL, input TDIN, input TIAKO);
endinterface

// File: rtl/qint_iak_master_qsync.sv
// Generic 2-flop synchronizer for asynchronous QBUS inputs.
module qsync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // both stages sample the pre-edge value and the chain really is two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/qint_iak_master.sv
// Processor-side QBUS interrupt master: priority decode against the PSW level
// and the bus-acquire / DIN / IAKO / vector-read acknowledge sequence.
module qint_iak_master
  import qint_iak_master_pkg::*;
#(
  parameter int DIN_IAK_DLY = DIN_IAK_DLY_DEF,
  parameter int DESKEW      = DESKEW_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RINIT,
  qint_iak_master_if.master qbus,
  input  logic [2:0]        cpu_priority,
  output logic              irq_pending,
  output logic [2:0]        irq_level,
  input  logic              iak_start,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              iak_busy,
  output logic [15:0]       vector,
  output logic [2:0]        vector_level,
  output logic              vector_valid,
  output logic              iak_timeout
);
  localparam int CNT_MAX = (TIMEOUT > DIN_IAK_DLY) ?
                           ((TIMEOUT > DESKEW) ? TIMEOUT : DESKEW) :
                           ((DIN_IAK_DLY > DESKEW) ? DIN_IAK_DLY : DESKEW);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DIN_IAK_DLY - 1);
  localparam logic [CNT_W-1:0] DESK_LAST = CNT_W'(DESKEW - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  logic             sync_clr;
  logic [4:7]       irq_s;
  logic             rply_s;
  iak_state_e       state, state_nxt;
  logic [CNT_W-1:0] dly_cnt, to_cnt;
  logic             cnt_clr, dly_inc, to_inc, capture, latch_vec, done_ok, done_to;

  // RINIT is a bus-wide abort with the same effect as reset on the FSM.
  assign sync_clr = reset | RINIT;

  qsync #(.W(4)) u_irq_sync  (.clk(clk), .reset(reset), .d(qbus.RIRQ),  .q(irq_s));
  qsync #(.W(1)) u_rply_sync (.clk(clk), .reset(reset), .d(qbus.RRPLY), .q(rply_s));

  always_ff @(posedge clk) begin
    if (sync_clr) irq_level <= '0;
    else          irq_level <= highest_irq(irq_s, cpu_priority);
  end
  assign irq_pending = (irq_level != 3'd0);

  always_ff @(posedge clk) begin
    if (sync_clr) state <= IAK_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    dly_inc   = 1'b0;
    to_inc    = 1'b0;
    capture   = 1'b0;
    latch_vec = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    unique case (state)
      IAK_IDLE: if (iak_start && irq_pending) begin
        capture   = 1'b1;
        state_nxt = IAK_BUSREQ;
      end
      IAK_BUSREQ: if (bus_gnt && !rply_s) begin
        cnt_clr   = 1'b1;
        state_nxt = IAK_DIN;
      end
      IAK_DIN: begin
        to_inc = 1'b1;
        if (to_cnt == TO_LAST)         state_nxt = IAK_ABORT;
        else if (dly_cnt == DLY_LAST)  state_nxt = IAK_IAK;
        else                           dly_inc   = 1'b1;
      end
      IAK_IAK: begin
        to_inc = 1'b1;
        if (rply_s) begin
          cnt_clr   = 1'b1;
          state_nxt = IAK_DESK;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IAK_ABORT;
        end
      end
      // Let RDAL settle behind the synchronized reply before sampling it.
      IAK_DESK: begin
        if (dly_cnt == DESK_LAST) begin
          latch_vec = 1'b1;
          state_nxt = IAK_REL;
        end else begin
          dly_inc = 1'b1;
        end
      end
      IAK_REL: if (!rply_s) begin
        done_ok   = 1'b1;
        state_nxt = IAK_IDLE;
      end
      IAK_ABORT: if (!rply_s) begin
        done_to   = 1'b1;
        state_nxt = IAK_IDLE;
      end
      default: state_nxt = IAK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      dly_cnt      <= '0;
      to_cnt       <= '0;
      vector       <= '0;
      vector_level <= '0;
      vector_valid <= 1'b0;
      iak_timeout  <= 1'b0;
    end else begin
      vector_valid <= done_ok;
      iak_timeout  <= done_to;
      if (cnt_clr) begin
        dly_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        if (dly_inc) dly_cnt <= dly_cnt + CNT_W'(1);
        if (to_inc)  to_cnt  <= to_cnt + CNT_W'(1);
      end
      if (capture)   vector_level <= irq_level;
      if (latch_vec) vector       <= qbus.RDAL & 16'hFFFC;
    end
  end

  // DIN stays asserted through deskew so the device keeps driving RDAL.
  assign qbus.TDIN  = (state == IAK_DIN) || (state == IAK_IAK) || (state == IAK_DESK);
  assign qbus.TIAKO = (state == IAK_IAK) || (state == IAK_DESK);
  assign bus_req    = (state != IAK_IDLE);
  assign iak_busy   = (state != IAK_IDLE);

endmodule

// File: tb/tb_qint_iak_master.sv
// Directed bench for qint_iak_master: a small device model answers IAK cycles,
// and every vector_valid / iak_timeout pulse is matched against a scoreboard.
module tb_qint_iak_master;

  typedef struct {
    logic        is_timeout;
    logic [15:0] vec;
    logic [2:0]  lvl;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        RINIT;
  logic [2:0]  cpu_priority;
  logic        irq_pending;
  logic [2:0]  irq_level;
  logic        iak_start;
  logic        bus_req;
  logic        bus_gnt;
  logic        iak_busy;
  logic [15:0] vector;
  logic [2:0]  vector_level;
  logic        vector_valid;
  logic        iak_timeout;

  qint_iak_master_if qbus ();

  qint_iak_master dut (
    .clk          (clk),
    .reset        (reset),
    .RINIT        (RINIT),
    .qbus         (qbus),
    .cpu_priority (cpu_priority),
    .irq_pending  (irq_pending),
    .irq_level    (irq_level),
    .iak_start    (iak_start),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .iak_busy     (iak_busy),
    .vector       (vector),
    .vector_level (vector_level),
    .vector_valid (vector_valid),
    .iak_timeout  (iak_timeout)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? qbus.TDIN : qbus.TIAKO;
  endfunction

  // Waits at negedges until TDIN (sel 0) / TIAKO (sel 1) equals val, within budget.
  task automatic wait_for(input int sel, input logic val, input int budget,
                          input string tag, output int cyc);
    cyc = 0;
    while (sig(sel) !== val && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, sig(sel), val);
  endtask

  task automatic pulse_start();
    iak_start = 1'b1;
    @(negedge clk);
    iak_start = 1'b0;
  endtask

  // Device model: reply after IAKO, hold until DIN negates, then release.
  task automatic device_reply(input logic [15:0] vec, input int dly, input string tag);
    int cyc;
    wait_for(1, 1'b1, 40, {tag, "_iako"}, cyc);
    repeat (dly) @(negedge clk);
    qbus.RDAL  = vec;
    qbus.RRPLY = 1'b1;
    wait_for(0, 1'b0, 40, {tag, "_din_neg"}, cyc);
    check({tag, "_iako_neg"}, qbus.TIAKO, 1'b0);
    qbus.RRPLY = 1'b0;
    qbus.RDAL  = '0;
  endtask

  always @(negedge clk) begin
    if (vector_valid === 1'b1 || iak_timeout === 1'b1) begin
      check("pulse_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_vector_valid", vector_valid, !e.is_timeout);
        check("sb_iak_timeout", iak_timeout, e.is_timeout);
        check("sb_vector", vector, e.vec);
        check("sb_vector_level", vector_level, e.lvl);
      end
    end
  end

  initial begin
    int  cyc;
    logic ok;
    reset        = 1'b1;
    RINIT        = 1'b0;
    cpu_priority = 3'd0;
    iak_start    = 1'b0;
    bus_gnt      = 1'b1;
    qbus.RIRQ    = '0;
    qbus.RRPLY   = 1'b0;
    qbus.RDAL    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_tdin", qbus.TDIN, 1'b0);
    check("rst_tiako", qbus.TIAKO, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_iak_busy", iak_busy, 1'b0);
    check("rst_irq_pending", irq_pending, 1'b0);
    check("rst_vector", vector, 16'h0000);

    // Basic acknowledge at level 5 over priority 3.
    cpu_priority = 3'd3;
    qbus.RIRQ[5] = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_irq_level", irq_level, 3'd5);
    check("t1_irq_pending", irq_pending, 1'b1);
    exp_q.push_back('{1'b0, 16'o000224, 3'd5});
    pulse_start();
    check("t1_tdin_lat1", qbus.TDIN, 1'b0);
    check("t1_bus_req", bus_req, 1'b1);
    @(negedge clk);
    check("t1_tdin_lat2", qbus.TDIN, 1'b1);
    wait_for(1, 1'b1, 20, "t1_tiako_rise", cyc);
    check("t1_din_iak_dly", cyc, 4);
    device_reply(16'o000227, 6, "t1");
    repeat (6) @(negedge clk);
    check("t1_drain", exp_q.size(), 0);
    check("t1_idle", iak_busy, 1'b0);

    // Priority masking: level 4 is not above priority 4.
    qbus.RIRQ    = '0;
    qbus.RIRQ[4] = 1'b1;
    cpu_priority = 3'd4;
    repeat (4) @(negedge clk);
    check("t2_irq_pending", irq_pending, 1'b0);
    check("t2_irq_level", irq_level, 3'd0);
    pulse_start();
    ok = 1'b1;
    repeat (6) begin
      if (bus_req !== 1'b0 || qbus.TDIN !== 1'b0 || iak_busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("t2_ignored", ok, 1'b1);

    // Highest level wins; a level change after capture is ignored.
    qbus.RIRQ[6] = 1'b1;
    qbus.RIRQ[7] = 1'b1;
    cpu_priority = 3'd0;
    repeat (4) @(negedge clk);
    check("t3_irq_level", irq_level, 3'd7);
    exp_q.push_back('{1'b0, 16'o000310, 3'd7});
    pulse_start();
    qbus.RIRQ[7] = 1'b0;
    device_reply(16'o000310, 3, "t3");
    repeat (6) @(negedge clk);
    check("t3_drain", exp_q.size(), 0);
    check("t3_vector_hold", vector, 16'o000310);

    // Passive release: IRQ drops, no reply, cycle times out.
    qbus.RIRQ    = '0;
    qbus.RIRQ[5] = 1'b1;
    cpu_priority = 3'd3;
    repeat (4) @(negedge clk);
    check("t4_irq_level", irq_level, 3'd5);
    exp_q.push_back('{1'b1, 16'o000310, 3'd5});
    pulse_start();
    qbus.RIRQ = '0;
    wait_for(0, 1'b1, 10, "t4_tdin_rise", cyc);
    wait_for(0, 1'b0, 300, "t4_tdin_fall", cyc);
    check("t4_timeout_cycles", cyc, 200);
    check("t4_tiako_neg", qbus.TIAKO, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_drain", exp_q.size(), 0);
    check("t4_vector_unchanged", vector, 16'o000310);

    // Bus grant wait.
    qbus.RIRQ[5] = 1'b1;
    bus_gnt      = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back('{1'b0, 16'o000164, 3'd5});
    pulse_start();
    ok = 1'b1;
    repeat (20) begin
      if (bus_req !== 1'b1 || qbus.TDIN !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("t5_hold_off", ok, 1'b1);
    bus_gnt = 1'b1;
    @(negedge clk);
    check("t5_tdin_after_gnt", qbus.TDIN, 1'b1);
    device_reply(16'o000164, 2, "t5");
    repeat (6) @(negedge clk);
    check("t5_drain", exp_q.size(), 0);

    // RINIT while in IAK: everything drops on the next edge, no pulses.
    pulse_start();
    wait_for(1, 1'b1, 20, "t6_tiako_rise", cyc);
    RINIT = 1'b1;
    @(negedge clk);
    RINIT = 1'b0;
    check("t6_tdin", qbus.TDIN, 1'b0);
    check("t6_tiako", qbus.TIAKO, 1'b0);
    check("t6_bus_req", bus_req, 1'b0);
    check("t6_iak_busy", iak_busy, 1'b0);
    check("t6_no_valid", vector_valid, 1'b0);
    check("t6_no_timeout", iak_timeout, 1'b0);
    check("t6_vector_cleared", vector, 16'h0000);
    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
